// File: rtl/mem_line_initiator.sv
// Line-wide memory initiator: optional dirty-victim writeback followed by a line fill,
// using a single-request mem_req/mem_ready handshake with a per-wait timeout.
`timescale 1ns/1ps
module mem_line_initiator #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_BITS    = 512,
  parameter int OFFSET_WIDTH = 6,
  parameter int TIMEOUT      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_wb,
  input  logic [ADDR_WIDTH-1:0] req_wb_addr,
  input  logic [LINE_BITS-1:0]  req_wb_line,
  output logic                  resp_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [LINE_BITS-1:0]  resp_line,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_BITS-1:0]  mem_wline,
  input  logic                  mem_ready,
  input  logic [LINE_BITS-1:0]  mem_rline,
  output logic [15:0]           fill_cnt,
  output logic [15:0]           wb_cnt
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_ISSUE = 3'd1,
    WB_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [WCW-1:0]          wait_cnt_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    req_ready_r, resp_valid_r, resp_err_r;
  logic [ADDR_WIDTH-1:0]   resp_addr_r, mem_addr_r, mem_addr_nx_s;
  logic [LINE_BITS-1:0]    resp_line_r, mem_wline_r, mem_wline_nx_s;
  logic                    mem_req_r, mem_wr_r, mem_req_nx_s, mem_wr_nx_s;
  logic [15:0]             fill_cnt_r, wb_cnt_r;
  logic                    accept_s, wb_done_s, rd_done_s, tmo_s, wait_exp_s;

  assign wait_exp_s = (wait_cnt_r == WAIT_LAST);

  // Next-state decode; mem_ready takes priority over an expiring wait counter.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    wb_done_s  = 1'b0;
    rd_done_s  = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          accept_s = 1'b1;
          if (req_wb) state_nx_s = WB_ISSUE;
          else        state_nx_s = RD_ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WB_ISSUE: state_nx_s = WB_WAIT;
      WB_WAIT: begin
        if (mem_ready) begin
          wb_done_s  = 1'b1;
          state_nx_s = RD_ISSUE;
        end else if (wait_exp_s) begin
          tmo_s      = 1'b1;
          state_nx_s = RESP;
        end else begin
          state_nx_s = WB_WAIT;
        end
      end
      RD_ISSUE: state_nx_s = RD_WAIT;
      RD_WAIT: begin
        if (mem_ready) begin
          rd_done_s  = 1'b1;
          state_nx_s = RESP;
        end else if (wait_exp_s) begin
          tmo_s      = 1'b1;
          state_nx_s = RESP;
        end else begin
          state_nx_s = RD_WAIT;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Memory bus values for the coming cycle; the bus idles at all-zero.
  always_comb begin
    mem_req_nx_s   = 1'b0;
    mem_wr_nx_s    = 1'b0;
    mem_addr_nx_s  = {ADDR_WIDTH{1'b0}};
    mem_wline_nx_s = {LINE_BITS{1'b0}};
    if (state_nx_s == WB_ISSUE) begin
      mem_req_nx_s   = 1'b1;
      mem_wr_nx_s    = 1'b1;
      mem_addr_nx_s  = req_wb_addr & ALIGN_MASK;
      mem_wline_nx_s = req_wb_line;
    end else if (state_nx_s == RD_ISSUE) begin
      mem_req_nx_s = 1'b1;
      if (accept_s) mem_addr_nx_s = req_addr & ALIGN_MASK;
      else          mem_addr_nx_s = addr_r;
    end else begin
      mem_req_nx_s = 1'b0;
    end
  end

  // State, latched request, registered outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      wait_cnt_r   <= {WCW{1'b0}};
      addr_r       <= {ADDR_WIDTH{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_addr_r  <= {ADDR_WIDTH{1'b0}};
      resp_line_r  <= {LINE_BITS{1'b0}};
      mem_req_r    <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wline_r  <= {LINE_BITS{1'b0}};
      fill_cnt_r   <= 16'd0;
      wb_cnt_r     <= 16'd0;
    end else begin
      state_r      <= state_nx_s;
      req_ready_r  <= (state_nx_s == IDLE);
      resp_valid_r <= (state_nx_s == RESP);
      resp_err_r   <= tmo_s;
      mem_req_r    <= mem_req_nx_s;
      mem_wr_r     <= mem_wr_nx_s;
      mem_addr_r   <= mem_addr_nx_s;
      mem_wline_r  <= mem_wline_nx_s;
      if (accept_s) addr_r <= req_addr & ALIGN_MASK;
      // Counter runs only while staying in a wait state, so any entry starts from zero.
      if ((state_r == WB_WAIT || state_r == RD_WAIT) && state_nx_s == state_r)
        wait_cnt_r <= wait_cnt_r + WCW'(1);
      else
        wait_cnt_r <= {WCW{1'b0}};
      if (rd_done_s) begin
        resp_line_r <= mem_rline;
        resp_addr_r <= addr_r;
      end else if (tmo_s) begin
        resp_line_r <= {LINE_BITS{1'b0}};
        resp_addr_r <= addr_r;
      end
      if (rd_done_s && fill_cnt_r != CNT_MAX) fill_cnt_r <= fill_cnt_r + 16'd1;
      if (wb_done_s && wb_cnt_r != CNT_MAX)   wb_cnt_r   <= wb_cnt_r + 16'd1;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_addr  = resp_addr_r;
  assign resp_line  = resp_line_r;
  assign mem_req    = mem_req_r;
  assign mem_wr     = mem_wr_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wline  = mem_wline_r;
  assign fill_cnt   = fill_cnt_r;
  assign wb_cnt     = wb_cnt_r;

endmodule

// File: tb/tb_mem_line_initiator.sv
// Bench for mem_line_initiator: behavioural line memory stub plus a transaction-level
// reference model (expected bus requests, responses and counts per miss request).
`timescale 1ns/1ps
module tb_mem_line_initiator;
  localparam int AW = 32, LB = 512, TMO = 16;

  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, req_wb;
  logic [AW-1:0] req_addr, req_wb_addr, resp_addr, mem_addr;
  logic [LB-1:0] req_wb_line, resp_line, mem_wline, mem_rline;
  logic resp_valid, resp_err, mem_req, mem_wr, mem_ready;
  logic [15:0] fill_cnt, wb_cnt;
  int total = 0, bad = 0;
  int exp_fill = 0, exp_wb = 0;

  always #5 clk = ~clk;

  mem_line_initiator #(.ADDR_WIDTH(AW), .LINE_BITS(LB), .OFFSET_WIDTH(6), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_line(req_wb_line),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_line(resp_line), .resp_err(resp_err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wline(mem_wline),
    .mem_ready(mem_ready), .mem_rline(mem_rline), .fill_cnt(fill_cnt), .wb_cnt(wb_cnt));

  typedef struct {logic wr; logic [AW-1:0] addr; logic [LB-1:0] wline; int t;} mreq_t;
  typedef struct {logic err; logic [AW-1:0] addr; logic [LB-1:0] line;} resp_t;
  mreq_t mreq_q[$];
  resp_t resp_q[$];
  logic [LB-1:0] stub_mem [bit [31:0]];
  logic [LB-1:0] ref_mem  [bit [31:0]];
  logic mem_ready_m = 1'b0, stray_ready = 1'b0;
  logic [LB-1:0] mem_rline_m = '0, stray_line = '0;
  int mem_lat = 4;
  bit mem_en = 1'b1;
  int cyc_now = 0;

  assign mem_ready = mem_ready_m | stray_ready;
  assign mem_rline = stray_ready ? stray_line : mem_rline_m;

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & 32'hFFFF_FFC0;
  endfunction

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LB-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    else return '0;
  endfunction

  // Line memory: takes one request when idle, answers mem_lat cycles later.
  initial begin : stub
    bit busy, op_wr;
    logic [AW-1:0] op_addr;
    logic [LB-1:0] op_data;
    int cnt;
    busy = 1'b0; cnt = 0; op_wr = 1'b0; op_addr = '0; op_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready_m = 1'b0; mem_rline_m = '0;
      if (busy) begin
        if (cnt <= 0) begin
          mem_ready_m = 1'b1; busy = 1'b0;
          if (op_wr) stub_mem[op_addr] = op_data;
          else if (stub_mem.exists(op_addr)) mem_rline_m = stub_mem[op_addr];
          else mem_rline_m = '0;
        end else cnt--;
      end else if (mem_req === 1'b1 && mem_en) begin
        busy = 1'b1; op_wr = mem_wr; op_addr = mem_addr; op_data = mem_wline; cnt = mem_lat - 1;
      end
    end
  end

  // Bus observer: logs requests and responses, checks pulse width and idle-bus zeros.
  initial begin : mon
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      cyc_now++;
      if (mem_req === 1'b1) begin
        mreq_q.push_back('{mem_wr, mem_addr, mem_wline, cyc_now});
        total++;
        if (prev_req === 1'b1) begin
          bad++; $display("FAIL mem_req_width: mem_req high 2 cycles, required 1 at cycle %0d", cyc_now);
        end
      end else if (mem_req === 1'b0) begin
        total++;
        if (mem_wr !== 1'b0 || mem_addr !== 32'd0 || mem_wline !== '0) begin
          bad++; $display("FAIL idle_bus: wr=%b addr=%h required 0 with mem_req=0", mem_wr, mem_addr);
        end
      end
      if (resp_valid === 1'b1) resp_q.push_back('{resp_err, resp_addr, resp_line});
      prev_req = mem_req;
    end
  end

  task automatic send_req(input logic [AW-1:0] a, input logic wb, input logic [AW-1:0] wa,
                          input logic [LB-1:0] wl);
    int k;
    req_addr = a; req_wb = wb; req_wb_addr = wa; req_wb_line = wl; req_valid = 1'b1; k = 0;
    while (req_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) begin
      total++; bad++; $display("FAIL send_req_wait: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_resp(input int bound, output bit got, output int cyc, output resp_t r);
    got = 1'b0; cyc = 0; r = '{1'b0, '0, '0};
    while (!got && cyc < bound) begin
      @(negedge clk); cyc++;
      if (resp_valid === 1'b1) begin got = 1'b1; r = '{resp_err, resp_addr, resp_line}; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h1234; req_wb = 1'b0;
    req_wb_addr = '0; req_wb_line = '0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_in_reset: %b required 1", req_ready); end
    total++; if (mreq_q.size() !== 0) begin bad++; $display("FAIL rst_no_accept: %0d reqs required 0", mreq_q.size()); end
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: %b required 1", req_ready); end
    total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp: v=%b e=%b required 0", resp_valid, resp_err); end
    total++; if (resp_addr !== 32'd0 || resp_line !== '0) begin bad++; $display("FAIL rst_resp_data: addr=%h required 0", resp_addr); end
    total++; if (mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 32'd0 || mem_wline !== '0) begin
      bad++; $display("FAIL rst_mem_bus: req=%b wr=%b addr=%h required 0", mem_req, mem_wr, mem_addr); end
    total++; if (fill_cnt !== 16'd0 || wb_cnt !== 16'd0) begin bad++; $display("FAIL rst_counts: fill=%0d wb=%0d required 0", fill_cnt, wb_cnt); end
  endtask

  task automatic test_clean_fill();
    logic [LB-1:0] l;
    bit got, prev_rdy;
    int k;
    l = '0;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'hA0 + 32'(i);
    stub_mem[32'h1000] = l; ref_mem[32'h1000] = l;
    mem_lat = 4; mreq_q.delete();
    send_req(32'h1024, 1'b0, 32'h0, '0);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fill_req_latency: mem_req=%b required 1", mem_req); end
    got = 1'b0; prev_rdy = 1'b0; k = 0;
    while (!got && k < 100) begin
      prev_rdy = (mem_ready === 1'b1);
      @(negedge clk); k++;
      got = (resp_valid === 1'b1);
    end
    exp_fill++;
    total++; if (!got) begin bad++; $display("FAIL fill_resp: no resp_valid, required one"); end
    total++; if (!prev_rdy) begin bad++; $display("FAIL fill_resp_timing: ready prior cycle=%b required 1", prev_rdy); end
    total++; if (resp_err !== 1'b0 || resp_line !== l) begin bad++; $display("FAIL fill_data: err=%b line=%h required %h", resp_err, resp_line, l); end
    total++; if (resp_addr !== 32'h1000) begin bad++; $display("FAIL fill_addr: %h required 00001000", resp_addr); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_during_resp: %b required 0", req_ready); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL fill_after_resp: v=%b rdy=%b required 0/1", resp_valid, req_ready); end
    total++; if (fill_cnt !== 16'(exp_fill) || wb_cnt !== 16'(exp_wb)) begin bad++; $display("FAIL fill_counts: fill=%0d wb=%0d required %0d/%0d", fill_cnt, wb_cnt, exp_fill, exp_wb); end
    total++; if (mreq_q.size() !== 1 || mreq_q[0].wr !== 1'b0 || mreq_q[0].addr !== 32'h1000) begin
      bad++; $display("FAIL fill_bus: %0d reqs, required one read at 00001000", mreq_q.size()); end
    repeat (3) @(negedge clk);
    total++; if (resp_line !== l || resp_addr !== 32'h1000) begin bad++; $display("FAIL fill_hold: addr=%h required 00001000", resp_addr); end
  endtask

  task automatic test_dirty_evict();
    logic [LB-1:0] l3, v;
    bit got; int cyc; resp_t r;
    l3 = rnd_line(); v = {64{8'h5A}};
    stub_mem[32'h3000] = l3; ref_mem[32'h3000] = l3; ref_mem[32'h2040] = v;
    mem_lat = 4; mreq_q.delete();
    send_req(32'h3000 | 32'($urandom_range(0, 63)), 1'b1, 32'h2040 | 32'($urandom_range(0, 63)), v);
    wait_resp(200, got, cyc, r);
    exp_wb++; exp_fill++;
    total++; if (!got || r.err !== 1'b0 || r.line !== l3 || r.addr !== 32'h3000) begin
      bad++; $display("FAIL evict_resp: got=%b err=%b addr=%h required 1/0/00003000", got, r.err, r.addr); end
    total++; if (mreq_q.size() !== 2) begin bad++; $display("FAIL evict_nreq: %0d required 2", mreq_q.size()); end
    else begin
      total++; if (mreq_q[0].wr !== 1'b1 || mreq_q[0].addr !== 32'h2040 || mreq_q[0].wline !== v) begin
        bad++; $display("FAIL evict_write: wr=%b addr=%h required 1/00002040", mreq_q[0].wr, mreq_q[0].addr); end
      total++; if (mreq_q[1].wr !== 1'b0 || mreq_q[1].addr !== 32'h3000) begin
        bad++; $display("FAIL evict_read: wr=%b addr=%h required 0/00003000", mreq_q[1].wr, mreq_q[1].addr); end
      total++; if (mreq_q[1].t - mreq_q[0].t !== mem_lat + 1) begin
        bad++; $display("FAIL evict_gap: %0d cycles required %0d", mreq_q[1].t - mreq_q[0].t, mem_lat + 1); end
    end
    total++; if (stub_mem[32'h2040] !== v) begin bad++; $display("FAIL evict_mem: %h required 5a..", stub_mem[32'h2040]); end
    total++; if (fill_cnt !== 16'(exp_fill) || wb_cnt !== 16'(exp_wb)) begin bad++; $display("FAIL evict_counts: fill=%0d wb=%0d required %0d/%0d", fill_cnt, wb_cnt, exp_fill, exp_wb); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [AW-1:0] a, wa; logic wb; logic [LB-1:0] wl, ex;
    bit got; int cyc; resp_t r; int nexp;
    for (int it = 0; it < 8; it++) begin
      a = 32'($urandom_range(0, 32'h3FF)); wa = 32'($urandom_range(0, 32'h3FF));
      wb = 1'($urandom_range(0, 1)); wl = rnd_line(); mem_lat = $urandom_range(1, 6);
      ex = rnd_line(); stub_mem[align(a)] = ex; ref_mem[align(a)] = ex;
      if (wb) ref_mem[align(wa)] = wl;
      ex = ref_read(align(a));
      nexp = wb ? 2 : 1;
      mreq_q.delete();
      send_req(a, wb, wa, wl);
      wait_resp(200, got, cyc, r);
      exp_fill++; if (wb) exp_wb++;
      total++; if (!got || r.err !== 1'b0 || r.line !== ex || r.addr !== align(a)) begin
        bad++; $display("FAIL rand_resp[%0d]: got=%b err=%b addr=%h required addr %h", it, got, r.err, r.addr, align(a)); end
      total++; if (mreq_q.size() !== nexp || mreq_q[nexp-1].wr !== 1'b0 || mreq_q[nexp-1].addr !== align(a)
                   || (wb && (mreq_q[0].wr !== 1'b1 || mreq_q[0].addr !== align(wa) || mreq_q[0].wline !== wl))) begin
        bad++; $display("FAIL rand_bus[%0d]: %0d reqs required %0d", it, mreq_q.size(), nexp); end
      total++; if (fill_cnt !== 16'(exp_fill) || wb_cnt !== 16'(exp_wb)) begin
        bad++; $display("FAIL rand_counts[%0d]: fill=%0d wb=%0d required %0d/%0d", it, fill_cnt, wb_cnt, exp_fill, exp_wb); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a[3]; logic [LB-1:0] ex[3];
    int idx, k; bit acc;
    mem_lat = $urandom_range(1, 3); mreq_q.delete(); resp_q.delete();
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'h4000 + 32'(i) * 32'h40 + 32'($urandom_range(0, 63));
      ex[i] = rnd_line(); stub_mem[align(a[i])] = ex[i]; ref_mem[align(a[i])] = ex[i];
    end
    idx = 0; k = 0;
    req_addr = a[0]; req_wb = 1'b0; req_valid = 1'b1;
    while (idx < 3 && k < 300) begin
      acc = (req_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) req_addr = a[idx];
        else req_valid = 1'b0;
      end
      @(negedge clk); k++;
    end
    req_valid = 1'b0;
    k = 0;
    while (resp_q.size() < 3 && k < 300) begin @(negedge clk); k++; end
    exp_fill += 3;
    total++; if (resp_q.size() !== 3) begin bad++; $display("FAIL b2b_nresp: %0d required 3", resp_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (resp_q[i].err !== 1'b0 || resp_q[i].addr !== align(a[i]) || resp_q[i].line !== ex[i]) begin
        bad++; $display("FAIL b2b_resp[%0d]: addr=%h required %h", i, resp_q[i].addr, align(a[i])); end
    end
    total++; if (mreq_q.size() !== 3) begin bad++; $display("FAIL b2b_nreq: %0d required 3", mreq_q.size()); end
    total++; if (fill_cnt !== 16'(exp_fill)) begin bad++; $display("FAIL b2b_fill_cnt: %0d required %0d", fill_cnt, exp_fill); end
  endtask

  task automatic test_timeout();
    bit got; int cyc; resp_t r; logic [LB-1:0] sl;
    mem_en = 1'b0; mreq_q.delete();
    send_req(32'h5555, 1'b0, 32'h0, '0);
    wait_resp(60, got, cyc, r);
    total++; if (!got || cyc !== TMO + 1) begin bad++; $display("FAIL tmo_rd_time: got=%b cyc=%0d required %0d", got, cyc, TMO + 1); end
    total++; if (r.err !== 1'b1 || r.line !== '0 || r.addr !== 32'h5540) begin
      bad++; $display("FAIL tmo_rd_resp: err=%b addr=%h required 1/00005540, line 0", r.err, r.addr); end
    @(negedge clk);
    mreq_q.delete();
    send_req(32'h6010, 1'b1, 32'h7000, rnd_line());
    wait_resp(60, got, cyc, r);
    total++; if (!got || cyc !== TMO + 1 || r.err !== 1'b1) begin bad++; $display("FAIL tmo_wb: got=%b cyc=%0d err=%b required %0d/1", got, cyc, r.err, TMO + 1); end
    total++; if (mreq_q.size() !== 1) begin bad++; $display("FAIL tmo_wb_skip_fill: %0d reqs required 1", mreq_q.size()); end
    total++; if (fill_cnt !== 16'(exp_fill) || wb_cnt !== 16'(exp_wb)) begin bad++; $display("FAIL tmo_counts: fill=%0d wb=%0d required %0d/%0d", fill_cnt, wb_cnt, exp_fill, exp_wb); end
    repeat (2) @(negedge clk);
    resp_q.delete(); mreq_q.delete();
    stray_line = rnd_line(); stray_ready = 1'b1;
    @(posedge clk); #1 stray_ready = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (resp_q.size() !== 0 || req_ready !== 1'b1 || fill_cnt !== 16'(exp_fill) || wb_cnt !== 16'(exp_wb)) begin
      bad++; $display("FAIL stray_ready: resps=%0d rdy=%b fill=%0d wb=%0d required 0/1/%0d/%0d", resp_q.size(), req_ready, fill_cnt, wb_cnt, exp_fill, exp_wb); end
    send_req(32'h8000, 1'b0, 32'h0, '0);
    repeat (TMO) @(negedge clk);
    sl = rnd_line(); stray_line = sl; stray_ready = 1'b1;
    @(posedge clk); #1 stray_ready = 1'b0;
    @(negedge clk);
    exp_fill++;
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_line !== sl) begin
      bad++; $display("FAIL ready_beats_timeout: v=%b err=%b required 1/0 with memory data", resp_valid, resp_err); end
    total++; if (fill_cnt !== 16'(exp_fill)) begin bad++; $display("FAIL ready_beats_timeout_cnt: %0d required %0d", fill_cnt, exp_fill); end
    @(negedge clk);
    mem_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    mem_lat = 10; mreq_q.delete();
    send_req(32'h9000, 1'b1, 32'h9040, rnd_line());
    repeat (2) @(negedge clk);
    resp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_fill = 0; exp_wb = 0;
    total++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_idle: rdy=%b req=%b v=%b required 1/0/0", req_ready, mem_req, resp_valid); end
    total++; if (fill_cnt !== 16'd0 || wb_cnt !== 16'd0) begin bad++; $display("FAIL midrst_counts: fill=%0d wb=%0d required 0", fill_cnt, wb_cnt); end
    repeat (20) @(negedge clk);
    total++; if (resp_q.size() !== 0 || mreq_q.size() !== 1 || wb_cnt !== 16'd0 || fill_cnt !== 16'd0) begin
      bad++; $display("FAIL midrst_late_ready: resps=%0d reqs=%0d wb=%0d required 0/1/0", resp_q.size(), mreq_q.size(), wb_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_fill();
    test_dirty_evict();
    test_random();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_line_initiator.md
# mem_line_initiator

Line-wide memory initiator between the L1 cache controller and the behavioral line memory. It accepts one miss request at a time from the cache, optionally writes back a dirty 512-bit victim line, and then fetches the missing 512-bit line. It drives the memory's single-request mem_req/mem_ready handshake. It returns the filled line, or an error on timeout, to the cache as a one-cycle response.

## Interface
- ADDR_WIDTH, 32, byte-address width
- LINE_BITS, 512, line width (64B)
- OFFSET_WIDTH, 6, line-offset bits zeroed on every outgoing address
- TIMEOUT, 1024, max cycles waited for mem_ready per transaction (≥2)
- clk  in  1  clock; everything is sampled on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- req_valid  in  1  cache miss request
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid && req_ready
- req_addr  in  ADDR_WIDTH  miss byte address (unaligned ok)
- req_wb  in  1  victim is dirty; write it back before the fill
- req_wb_addr  in  ADDR_WIDTH  victim byte address
- req_wb_line  in  LINE_BITS  victim data
- resp_valid  out  1  one-cycle response pulse
- resp_addr  out  ADDR_WIDTH  aligned fill address
- resp_line  out  LINE_BITS  filled line (0 on error)
- resp_err  out  1  qualifies resp_valid; 1 = timeout
- mem_req  out  1  one-cycle request pulse to memory
- mem_wr  out  1  1 = write line, 0 = read line
- mem_addr  out  ADDR_WIDTH  line-aligned address
- mem_wline  out  LINE_BITS  write data
- mem_ready  in  1  one-cycle completion pulse from memory
- mem_rline  in  LINE_BITS  read data, valid while mem_ready = 1
- fill_cnt, wb_cnt  out  16 each  saturating counts of completed fills and writebacks

## Operation
- States: IDLE, WB_ISSUE, WB_WAIT, RD_ISSUE, RD_WAIT, RESP.
- IDLE: on accept, latch all req_* fields with offset bits cleared. Go to WB_ISSUE if req_wb = 1, otherwise RD_ISSUE.
- WB_ISSUE: mem_req=1, mem_wr=1, mem_addr=aligned wb addr, mem_wline=wb line. Lasts exactly one cycle, then WB_WAIT.
- WB_WAIT: on mem_ready, wb_cnt++ and go to RD_ISSUE.
- RD_ISSUE: mem_req=1, mem_wr=0, mem_addr=aligned miss addr. Lasts one cycle, then RD_WAIT.
- RD_WAIT: on mem_ready, capture mem_rline into resp_line, fill_cnt++, go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- mem_req is never held for more than one cycle. The memory ignores requests while busy and re-accepts a held request.
- When mem_req=0, mem_wr, mem_addr and mem_wline are 0.
- Timeout:
  - A wait counter clears on entry to each WAIT state.
  - If TIMEOUT cycles elapse in a WAIT state without mem_ready, go to RESP with resp_err=1 and resp_line=0.
  - A writeback timeout skips the fill.
- If mem_ready and timeout expiry fall in the same cycle, mem_ready wins.
- mem_ready outside the WAIT states (e.g. a late pulse after a timeout) is ignored: no state change, no counter change.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (rst_n=0 at an edge) returns to IDLE from any state, including mid-transaction.
- Reset values:
  - req_ready=1 from the first cycle after reset.
  - resp_valid=0, resp_err=0, resp_addr=0, resp_line=0.
  - mem_req=0, mem_wr=0, mem_addr=0, mem_wline=0.
  - fill_cnt=0, wb_cnt=0.
- Accept at edge T → mem_req high during cycle T+1.
- mem_ready sampled at edge R in RD_WAIT → resp_valid high during cycle R+1 → req_ready high again at R+2.
- Writeback: mem_ready at edge W → fill mem_req high during cycle W+1.
- The added latency with no writeback is 3 cycles beyond the memory's own latency.
- resp_addr and resp_line hold their last values until the next response.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles with req_valid=1.
  - Response: all outputs at their reset values; no request accepted.
- Clean fill:
  - Stimulus: preload memory line 0x1000 with words 0..15 = 0xA0+i, memory latency 4; request req_addr=0x1024, req_wb=0.
  - Response: one mem_req with mem_addr=0x1000, mem_wr=0; resp_line matches the preload; resp_err=0; fill_cnt=1.
- Dirty eviction:
  - Stimulus: req_wb=1, req_wb_addr=0x2040, req_wb_line=all 0x5A; fill from 0x3000.
  - Response: write mem_req precedes read mem_req; memory at 0x2040 holds 0x5A..; wb_cnt=1, fill_cnt=1.
- Timeout:
  - Stimulus: TIMEOUT=16, memory stub never asserts mem_ready.
  - Response: resp_valid with resp_err=1, resp_line=0 at 16 cycles after entering RD_WAIT; a later stray mem_ready is ignored.
- Back-to-back:
  - Stimulus: req_valid held high for three requests.
  - Response: each mem_req is exactly 1 cycle wide; a new request is accepted only on cycles where req_ready=1; three responses arrive in order.
- Mid-transaction reset:
  - Stimulus: assert rst_n=0 during WB_WAIT.
  - Response: IDLE next cycle; no resp_valid; counters cleared.
